prog_delay_line: RTL and testbench
==================================

// Module: prog_delay_line
// PURPOSE
//  Parametrised successor to the single fixed delay cell on the datapath: a multi-channel,
//  clocked delay line whose depth is programmable at run time. Every channel is delayed by
//  the same number of cycles. Sits between the input pads and the core logic in the
//  physical netlist. Depth changes are made safe by draining in-flight data first.
// PARAMETERS
//  WIDTH      8  data bits per channel
//  CHANNELS   4  parallel channels sharing one delay setting
//  MAX_DEPTH 16  maximum delay in cycles (>=1)
//  DEF_DELAY  1  delay applied out of reset (1..MAX_DEPTH)
// PORTS
//  clk        in    1                      clock, rising edge
//  rst        in    1                      reset: asynchronous, active-high
//  in_valid   in    1                      input word present
//  in_ready   out   1                      line accepts input this cycle
//  in_data    in    WIDTH*CHANNELS         channel c occupies bits [c*WIDTH +: WIDTH]
//  out_valid  out   1                      delayed word present
//  out_data   out   WIDTH*CHANNELS         delayed data, same channel packing
//  cfg_delay  in    $clog2(MAX_DEPTH+1)    requested delay
//  cfg_load   in    1                      one-cycle strobe; captures cfg_delay
//  cur_delay  out   $clog2(MAX_DEPTH+1)    delay currently in effect
//  busy       out   1                      drain in progress
//  VDD, VSS   inout 1                      power / ground
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids = 0, out_valid = 0, out_data = 0,
//    cur_delay = DEF_DELAY, busy = 0, in_ready = 1, state = RUN, in-flight count = 0.
//  - Clamping on capture: cfg_delay = 0 -> 1; cfg_delay > MAX_DEPTH -> MAX_DEPTH.
//  - Latency: a word accepted on edge k (in_valid & in_ready) appears with out_valid = 1
//    for exactly one cycle after edge k+cur_delay. There is no output backpressure.
//  - Data registers are updated only when the stage valid is set; valid=0 stages hold
//    their previous data. out_data is 0 whenever out_valid = 0.
//  - In-flight counter: +1 on accept, -1 on emit, both in the same cycle -> unchanged.
//    It never exceeds cur_delay.
//  - FSM RUN:
//    - in_ready = 1.
//    - cfg_load with the clamped value == cur_delay: no-op, stay in RUN.
//    - Otherwise capture the value into pending and go to DRAIN.
//    - cfg_load together with in_valid: the input word is accepted and carried at the old delay.
//  - FSM DRAIN:
//    - in_ready = 0, busy = 1; the line keeps shifting.
//    - A further cfg_load overwrites pending (last write wins).
//    - When the in-flight count reaches 0: cur_delay <= pending, go to RUN.
//      in_ready returns to 1 on the next cycle.
//    - If nothing is in flight on entry, DRAIN lasts exactly one cycle.
//  - Reset mid-drain: drops all in-flight words and discards pending.
// STRUCTURE
//  - Package prog_delay_pkg holds:
//    - the state typedef {ST_RUN, ST_DRAIN};
//    - the function clamp_delay(value, MAX_DEPTH);
//    - the localparam CNT_W = $clog2(MAX_DEPTH+1).
//  - Sub-module delay_stage: one register slice (valid + WIDTH*CHANNELS data, load-enable).
//    - Instantiate MAX_DEPTH copies in a generate loop.
//  - Output mux: selects stage cur_delay-1.
//  - Top level contains only the FSM, the counter and the mux.
// TESTING
//  1 Reset, DEF_DELAY=1: in_valid=1, in_data=32'hA1B2C3D4 -> out_valid one cycle later,
//    out_data=32'hA1B2C3D4, cur_delay=1.
//  2 cfg_delay=5 with the line idle -> busy for 1 cycle, then cur_delay=5.
//    Then stream 0x01..0x0A back-to-back -> each emitted 5 cycles after accept, in order,
//    no gaps.
//  3 Streaming at delay 5, cfg_load with cfg_delay=2 on the last accept ->
//    - in_ready=0 until all 5 in-flight words exit at delay 5;
//    - then cur_delay=2, and the next word exits 2 cycles after accept.
//  4 cfg_delay=0 -> cur_delay=1; cfg_delay=31 with MAX_DEPTH=16 -> cur_delay=16.
//    Same-value load (16 again) -> busy stays 0.
//  5 During DRAIN, cfg_load with 3 then with 7 -> cur_delay=7 after the drain.
//  6 Assert rst mid-drain with 3 words in flight ->
//    - out_valid=0 immediately and no stale words emitted;
//    - cur_delay=DEF_DELAY, busy=0, in_ready=1 after release.

Source files
------------

// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package prog_delay_pkg;

    localparam int unsigned MAX_DEPTH_DFLT = 16;
    localparam int unsigned CNT_W = $clog2(MAX_DEPTH_DFLT + 1);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic int unsigned clamp_delay(input int unsigned value,
                                                input int unsigned max_depth);
        if (value == 0) begin
            return 1;
        end
        if (value > max_depth) begin
            return max_depth;
        end
        return value;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One slice of the delay line: a valid flag plus a data word that only loads when valid.
module delay_stage #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel delay line with run-time programmable depth; depth changes wait for the
// line to drain so no word is ever emitted at a mixed delay.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned DEF_DELAY = 1,
    localparam int unsigned DW       = WIDTH * CHANNELS,
    localparam int unsigned CW       = $clog2(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic [CW-1:0] cfg_delay,
    input  logic          cfg_load,
    output logic [CW-1:0] cur_delay,
    output logic          busy,
    inout  wire           VDD,
    inout  wire           VSS
);

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_cur_delay, w_cur_next;
    logic [CW-1:0]         r_pending, w_pending_next;
    logic [CW-1:0]         r_count, w_count_next;
    logic [CW-1:0]         w_cfg_clamped;
    logic                  w_accept, w_sel_valid;
    logic [DW-1:0]         w_sel_data;
    logic                  r_out_valid;
    logic [DW-1:0]         r_out_data;
    logic [MAX_DEPTH-1:0]  w_chain_valid, w_stage_valid;
    logic [DW-1:0]         w_chain_data [MAX_DEPTH];
    logic [DW-1:0]         w_stage_data [MAX_DEPTH];

    assign w_accept      = in_valid & in_ready;
    assign w_cfg_clamped = CW'(clamp_delay(32'(cfg_delay), MAX_DEPTH));

    // Words past the active tap are dropped so a later, longer delay never sees stale data.
    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_chain_valid[k] = w_accept;
            assign w_chain_data[k]  = in_data;
        end else begin : g_body
            assign w_chain_valid[k] = w_stage_valid[k-1] & (CW'(k) < r_cur_delay);
            assign w_chain_data[k]  = w_stage_data[k-1];
        end
        delay_stage #(.DW(DW)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_valid(w_chain_valid[k]),
            .i_data (w_chain_data[k]),
            .o_valid(w_stage_valid[k]),
            .o_data (w_stage_data[k])
        );
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (r_cur_delay == CW'(i + 1)) begin
                w_sel_valid = w_stage_valid[i];
                w_sel_data  = w_stage_data[i];
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_cur_next     = r_cur_delay;
        w_count_next   = r_count + CW'(w_accept) - CW'(w_sel_valid);
        unique case (r_state)
            ST_RUN: begin
                if (cfg_load && (w_cfg_clamped != r_cur_delay)) begin
                    w_pending_next = w_cfg_clamped;
                    w_state_next   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cfg_load) begin
                    w_pending_next = w_cfg_clamped;
                end
                if (r_count == '0) begin
                    w_cur_next   = w_pending_next;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cur_delay <= CW'(DEF_DELAY);
            r_pending   <= CW'(DEF_DELAY);
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cur_delay <= w_cur_next;
            r_pending   <= w_pending_next;
            r_count     <= w_count_next;
            r_out_valid <= w_sel_valid;
            r_out_data  <= w_sel_valid ? w_sel_data : '0;
        end
    end

    assign in_ready  = (r_state == ST_RUN);
    assign busy      = (r_state == ST_DRAIN);
    assign cur_delay = r_cur_delay;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed and random checks of prog_delay_line against a queue-based timing model.
module tb_prog_delay_line;

    localparam int unsigned MAXD = 16;
    localparam int unsigned DEFD = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  cfg_delay;
    logic        cfg_load;
    logic [4:0]  cur_delay;
    logic        busy;
    wire         vdd = 1'b1;
    wire         vss = 1'b0;

    prog_delay_line #(
        .WIDTH    (8),
        .CHANNELS (4),
        .MAX_DEPTH(MAXD),
        .DEF_DELAY(DEFD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .cfg_delay(cfg_delay),
        .cfg_load (cfg_load),
        .cur_delay(cur_delay),
        .busy     (busy),
        .VDD      (vdd),
        .VSS      (vss)
    );

    always #5 clk = ~clk;

    // Model: each accepted word is scheduled for the edge at which it must appear.
    typedef struct {
        int          t;
        logic [31:0] d;
    } sched_t;

    sched_t      m_q[$];
    int          cyc = 0;
    bit          m_drain = 0;
    int          m_cur = DEFD;
    int          m_pending = DEFD;
    logic        exp_ov = 1'b0;
    logic [31:0] exp_od = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic int clampm(input int v);
        return (v == 0) ? 1 : ((v > int'(MAXD)) ? int'(MAXD) : v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
        check({tag, "_out_data"}, out_data, exp_od);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(!m_drain));
        check({tag, "_busy"}, 32'(busy), 32'(m_drain));
        check({tag, "_cur_delay"}, 32'(cur_delay), 32'(m_cur));
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic ld,
                              input logic [4:0] cfg);
        bit empty_pre;
        bit acc;
        cyc++;
        empty_pre = (m_q.size() == 0);
        acc = v && !m_drain;
        if (m_q.size() > 0 && m_q[0].t == cyc) begin
            exp_ov = 1'b1;
            exp_od = m_q[0].d;
            void'(m_q.pop_front());
        end else begin
            exp_ov = 1'b0;
            exp_od = '0;
        end
        if (acc) m_q.push_back('{t: cyc + m_cur, d: d});
        if (!m_drain) begin
            if (ld && clampm(int'(cfg)) != m_cur) begin
                m_pending = clampm(int'(cfg));
                m_drain = 1;
            end
        end else begin
            if (ld) m_pending = clampm(int'(cfg));
            if (empty_pre) begin
                m_cur = m_pending;
                m_drain = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic ld, input logic [4:0] cfg);
        in_valid  = v;
        in_data   = d;
        cfg_load  = ld;
        cfg_delay = cfg;
        @(posedge clk);
        model_edge(v, d, ld, cfg);
        #1;
        check_all(tag);
    endtask

    task automatic idle_until_run(input string tag);
        int guard = 0;
        while (m_drain && guard < 40) begin
            step(tag, 1'b0, 32'h0, 1'b0, 5'd0);
            guard++;
        end
        check({tag, "_drain_bound"}, 32'(m_drain), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        cfg_load = 1'b0;
        cfg_delay = '0;
        #12;
        rst = 1'b0;
        #1;
        check_all("reset");

        // 1: default delay of one cycle
        step("t1_acc", 1'b1, 32'hA1B2C3D4, 1'b0, 5'd0);
        step("t1_out", 1'b0, 32'h0, 1'b0, 5'd0);
        check("t1_data", out_data, 32'hA1B2C3D4);
        step("t1_idle", 1'b0, 32'h0, 1'b0, 5'd0);

        // 2: idle reprogram to 5, then a back-to-back stream
        step("t2_load", 1'b0, 32'h0, 1'b1, 5'd5);
        check("t2_busy", 32'(busy), 32'(1));
        step("t2_drain", 1'b0, 32'h0, 1'b0, 5'd0);
        check("t2_cur", 32'(cur_delay), 32'(5));
        for (int i = 1; i <= 10; i++) step("t2_stream", 1'b1, 32'(i), 1'b0, 5'd0);
        for (int i = 0; i < 6; i++) step("t2_flush", 1'b0, 32'h0, 1'b0, 5'd0);

        // 3: shrink to 2 on the last accept of a stream
        for (int i = 1; i <= 4; i++) step("t3_stream", 1'b1, 32'(16 + i), 1'b0, 5'd0);
        step("t3_lastload", 1'b1, 32'h15, 1'b1, 5'd2);
        idle_until_run("t3_drain");
        check("t3_cur", 32'(cur_delay), 32'(2));
        step("t3_acc", 1'b1, 32'hCAFE0002, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) step("t3_out", 1'b0, 32'h0, 1'b0, 5'd0);

        // 4: clamping and same-value load
        step("t4_load0", 1'b0, 32'h0, 1'b1, 5'd0);
        idle_until_run("t4_drain0");
        check("t4_clamp_lo", 32'(cur_delay), 32'(1));
        step("t4_load31", 1'b0, 32'h0, 1'b1, 5'd31);
        idle_until_run("t4_drain31");
        check("t4_clamp_hi", 32'(cur_delay), 32'(16));
        step("t4_same", 1'b0, 32'h0, 1'b1, 5'd16);
        check("t4_same_busy", 32'(busy), 32'(0));

        // 5: last write wins during drain
        for (int i = 0; i < 3; i++) step("t5_fill", 1'b1, 32'(32'h500 + i), 1'b0, 5'd0);
        step("t5_load3", 1'b0, 32'h0, 1'b1, 5'd3);
        step("t5_load7", 1'b0, 32'h0, 1'b1, 5'd7);
        idle_until_run("t5_drain");
        check("t5_cur", 32'(cur_delay), 32'(7));

        // 6: reset in the middle of a drain with three words in flight
        step("t6_acc", 1'b1, 32'h601, 1'b0, 5'd0);
        step("t6_acc", 1'b1, 32'h602, 1'b0, 5'd0);
        step("t6_accload", 1'b1, 32'h603, 1'b1, 5'd2);
        step("t6_drain", 1'b0, 32'h0, 1'b0, 5'd0);
        in_valid = 1'b0;
        cfg_load = 1'b0;
        rst = 1'b1;
        #1;
        m_q.delete();
        m_drain = 0;
        m_cur = DEFD;
        m_pending = DEFD;
        exp_ov = 1'b0;
        exp_od = '0;
        check_all("t6_inrst");
        @(posedge clk);
        cyc++;
        #2;
        rst = 1'b0;
        #1;
        check_all("t6_release");
        for (int i = 0; i < 10; i++) step("t6_after", 1'b0, 32'h0, 1'b0, 5'd0);

        // Random traffic with occasional reprogramming
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 19) == 0),
                 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 20; i++) step("rand_flush", 1'b0, 32'h0, 1'b0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
